// File: rtl/collatz_inv_walk.sv
// Inverse-Collatz walker: builds a start value whose forward orbit hits the seed in len steps.
// Define COLLATZ_INV_CHECK_EN to add a forward-recurrence self-check before the result.
module collatz_inv_walk #(
    parameter int unsigned W  = 20,
    parameter int unsigned PW = 16,
    parameter int unsigned LW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st,
    input  logic [W-1:0]  seed,
    input  logic [PW-1:0] path,
    input  logic [LW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  n_out,
    output logic [LW-1:0] orbit,
    output logic [LW-1:0] odd_cnt,
    output logic [PW-1:0] taken,
    output logic          ovf,
    output logic          err,
    output logic          chk_ok
);

    localparam int unsigned Iw = (PW > 1) ? $clog2(PW) : 1;
    localparam logic [W-1:0] Three = W'(3);
    localparam logic [W-1:0] One   = W'(1);

    typedef enum logic [1:0] {StIdle, StStep, StCheck, StDone} state_e;

    state_e        state;
    logic [W-1:0]  k;
    logic [PW-1:0] path_q;
    logic [LW-1:0] len_q;

    logic [W-1:0]  km1, q, mod3, k_nxt;
    logic [Iw-1:0] idx;
    logic          odd_ok, step_ovf, last_step;

    // Inverse odd branch is only taken when it lands on an odd q > 1 (avoids the 1-4-2-1 loop).
    assign km1       = k - One;
    assign q         = km1 / Three;
    assign mod3      = km1 % Three;
    assign idx       = orbit[Iw-1:0];
    assign odd_ok    = path_q[idx] && (mod3 == '0) && q[0] && (q > One);
    assign k_nxt     = odd_ok ? q : (k << 1);
    assign step_ovf  = !odd_ok && k[W-1];
    assign last_step = (orbit + LW'(1)) == len_q;

`ifdef COLLATZ_INV_CHECK_EN
    logic [W-1:0]  seed_q, c_q, c_fwd;
    logic [LW-1:0] chk_cnt;

    assign c_fwd = c_q[0] ? ((c_q << 1) + c_q + One) : (c_q >> 1);
`else
    assign chk_ok = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
            err     <= 1'b0;
            n_out   <= '0;
            orbit   <= '0;
            odd_cnt <= '0;
            taken   <= '0;
            k       <= '0;
            path_q  <= '0;
            len_q   <= '0;
`ifdef COLLATZ_INV_CHECK_EN
            chk_ok  <= 1'b0;
            seed_q  <= '0;
            c_q     <= '0;
            chk_cnt <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (st) begin
                        k       <= seed;
                        path_q  <= path;
                        len_q   <= len;
                        orbit   <= '0;
                        odd_cnt <= '0;
                        taken   <= '0;
                        ovf     <= 1'b0;
                        err     <= 1'b0;
`ifdef COLLATZ_INV_CHECK_EN
                        chk_ok  <= 1'b0;
                        seed_q  <= seed;
`endif
                        if (seed == '0 || 32'(len) > PW) begin
                            err   <= 1'b1;
                            state <= StDone;
                            done  <= 1'b1;
                            n_out <= seed;
                        end else if (len == '0) begin
                            state <= StDone;
                            done  <= 1'b1;
                            n_out <= seed;
                        end else begin
                            state <= StStep;
                            busy  <= 1'b1;
                        end
                    end
                end
                StStep: begin
                    if (step_ovf) begin
                        ovf   <= 1'b1;
                        state <= StDone;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        n_out <= k;
                    end else begin
                        k     <= k_nxt;
                        orbit <= orbit + LW'(1);
                        if (odd_ok) begin
                            odd_cnt    <= odd_cnt + LW'(1);
                            taken[idx] <= 1'b1;
                        end
                        if (last_step) begin
`ifdef COLLATZ_INV_CHECK_EN
                            state   <= StCheck;
                            c_q     <= k_nxt;
                            chk_cnt <= '0;
`else
                            state <= StDone;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            n_out <= k_nxt;
`endif
                        end
                    end
                end
`ifdef COLLATZ_INV_CHECK_EN
                StCheck: begin
                    c_q     <= c_fwd;
                    chk_cnt <= chk_cnt + LW'(1);
                    if ((chk_cnt + LW'(1)) == orbit) begin
                        state  <= StDone;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        n_out  <= k;
                        chk_ok <= (c_fwd == seed_q);
                    end
                end
`endif
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_collatz_inv_walk.sv
// Scoreboard bench for collatz_inv_walk: directed walks with hand-computed results.
module tb_collatz_inv_walk;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st  = 1'b0;
    logic [19:0] seed = '0;
    logic [15:0] path = '0;
    logic [4:0]  len  = '0;
    logic        busy, done, ovf, err, chk_ok;
    logic [19:0] n_out;
    logic [4:0]  orbit, odd_cnt;
    logic [15:0] taken;

    collatz_inv_walk #(.W(20), .PW(16), .LW(5)) dut (
        .clk(clk), .rst(rst), .st(st), .seed(seed), .path(path), .len(len),
        .busy(busy), .done(done), .n_out(n_out), .orbit(orbit), .odd_cnt(odd_cnt),
        .taken(taken), .ovf(ovf), .err(err), .chk_ok(chk_ok)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [19:0] n;
        logic [4:0]  orb;
        logic [4:0]  odd;
        logic [15:0] tk;
        logic        ovf;
        logic        err;
        logic        ck;
        int          at;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

`ifdef COLLATZ_INV_CHECK_EN
    localparam bit ChkEn = 1'b1;
`else
    localparam bit ChkEn = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1, expected no result (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("n_out",   32'(n_out),   32'(e.n));
                check("orbit",   32'(orbit),   32'(e.orb));
                check("odd_cnt", 32'(odd_cnt), 32'(e.odd));
                check("taken",   32'(taken),   32'(e.tk));
                check("ovf",     32'(ovf),     32'(e.ovf));
                check("err",     32'(err),     32'(e.err));
                check("chk_ok",  32'(chk_ok),  32'(e.ck));
                check("busy_at_done", 32'(busy), 32'd0);
                check("done_cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    // Issue one start; early_lat = 0 means a full walk whose latency depends on the build.
    task automatic launch(input logic [19:0] s, input logic [15:0] p, input logic [4:0] l,
                          input logic [19:0] en, input logic [4:0] eorb, input logic [4:0] eodd,
                          input logic [15:0] etk, input logic eovf, input logic eerr,
                          input int early_lat);
        exp_t e;
        @(negedge clk);
        seed = s; path = p; len = l; st = 1'b1;
        e.n = en; e.orb = eorb; e.odd = eodd; e.tk = etk; e.ovf = eovf; e.err = eerr;
        e.ck = (early_lat == 0) && ChkEn;
        if (early_lat != 0)  e.at = cyc + early_lat;
        else if (ChkEn)      e.at = cyc + 2 * int'(l) + 1;
        else                 e.at = cyc + int'(l) + 1;
        exp_q.push_back(e);
        @(negedge clk);
        st = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done, expected %0d pending results", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic run(input logic [19:0] s, input logic [15:0] p, input logic [4:0] l,
                       input logic [19:0] en, input logic [4:0] eorb, input logic [4:0] eodd,
                       input logic [15:0] etk, input logic eovf, input logic eerr,
                       input int early_lat);
        launch(s, p, l, en, eorb, eodd, etk, eovf, eerr, early_lat);
        drain();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_n_out", 32'(n_out), 32'd0);
        check("rst_taken", 32'(taken), 32'd0);
        rst = 1'b0;

        //   seed      path     len  n_out     orb odd taken    ovf err early
        run(20'd1,    16'h0000, 5'd4, 20'd16,   5'd4, 5'd0, 16'h0000, 0, 0, 0);
        run(20'd16,   16'h0001, 5'd1, 20'd5,    5'd1, 5'd1, 16'h0001, 0, 0, 0);
        run(20'd10,   16'h0001, 5'd1, 20'd3,    5'd1, 5'd1, 16'h0001, 0, 0, 0);
        run(20'd4,    16'h0001, 5'd1, 20'd8,    5'd1, 5'd0, 16'h0000, 0, 0, 0);
        run(20'd1,    16'h0010, 5'd5, 20'd5,    5'd5, 5'd1, 16'h0010, 0, 0, 0);
        run(20'd7,    16'h0001, 5'd1, 20'd14,   5'd1, 5'd0, 16'h0000, 0, 0, 0);
        run(20'd40,   16'h0001, 5'd1, 20'd13,   5'd1, 5'd1, 16'h0001, 0, 0, 0);
        run(20'd16,   16'h0003, 5'd2, 20'd10,   5'd2, 5'd1, 16'h0001, 0, 0, 0);
        run(20'h80000, 16'h0000, 5'd3, 20'h80000, 5'd0, 5'd0, 16'h0000, 1, 0, 2);
        run(20'd0,    16'h0000, 5'd3, 20'd0,    5'd0, 5'd0, 16'h0000, 0, 1, 1);
        run(20'd5,    16'h0000, 5'd17, 20'd5,   5'd0, 5'd0, 16'h0000, 0, 1, 1);
        run(20'd7,    16'h0000, 5'd0, 20'd7,    5'd0, 5'd0, 16'h0000, 0, 0, 1);

        // Start pulsed mid-walk and again while done is high: both must be ignored.
        launch(20'd1, 16'h0000, 5'd4, 20'd16, 5'd4, 5'd0, 16'h0000, 0, 0, 0);
        check("busy_in_step", 32'(busy), 32'd1);
        seed = 20'd3; path = 16'hffff; len = 5'd2; st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        for (int i = 0; i < 40 && !done; i++) @(negedge clk);
        st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        drain();
        repeat (8) @(negedge clk);

        // Reset in cycle 2 of a long walk: no result, everything cleared.
        @(negedge clk);
        seed = 20'd1; path = 16'h0000; len = 5'd8; st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy",    32'(busy),    32'd0);
        check("abort_done",    32'(done),    32'd0);
        check("abort_n_out",   32'(n_out),   32'd0);
        check("abort_orbit",   32'(orbit),   32'd0);
        check("abort_odd_cnt", 32'(odd_cnt), 32'd0);
        check("abort_ovf_err", 32'({ovf, err, chk_ok}), 32'd0);
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/collatz_inv_walk.md
Name: collatz_inv_walk

Overview:
- Inverse-Collatz generator; the reverse direction of the forward orbit datapath.
- Starts from a seed value and walks the Collatz tree backwards for a programmed number of steps. A path word chooses, per step, the doubling branch or the (k-1)/3 branch.
- Produces a start value whose forward orbit reaches the seed in exactly the walked number of steps.
- Used to generate stimulus and known-answer vectors for the forward orbit unit.

Parameters:
- W, 20, width of the value register (matches forward datapath value width)
- PW, 16, path word width = maximum step count
- LW, 5, width of len / orbit counters (must hold PW)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- st  in  1  start; sampled only in IDLE
- seed  in  W  tree node to walk back from
- path  in  PW  branch selects, bit i used at step i (LSB first)
- len  in  LW  number of inverse steps, 0..PW
- busy  out  1  high in STEP (and CHECK when enabled)
- done  out  1  one-cycle pulse when a result is valid
- n_out  out  W  resulting start value
- orbit  out  LW  inverse steps completed
- odd_cnt  out  LW  number of (k-1)/3 branches taken
- taken  out  PW  bit i = 1 if step i took the (k-1)/3 branch
- ovf  out  1  doubling overflowed W bits
- err  out  1  illegal seed (0) or len > PW
- chk_ok  out  1  forward self-check passed (see Optional Feature)

Behaviour:
- Reset (synchronous, active-high, any state): state = IDLE. busy, done, ovf, err, chk_ok = 0. n_out, orbit, odd_cnt, taken = 0.
- IDLE:
  - st = 1 at a clock edge latches seed into k, path, and len.
  - Clears orbit, odd_cnt, taken, ovf, err, chk_ok.
  - seed = 0 or len > PW: err = 1, next state DONE.
  - len = 0: next state DONE.
  - Otherwise: next state STEP.
- STEP: one inverse step per cycle at index i = orbit.
  - Odd branch is legal when path[i] = 1, (k-1) mod 3 = 0, q = (k-1)/3 is odd, and q > 1. The q > 1 rule excludes the 1-4-2-1 loop.
  - Legal odd branch: k <= q; taken[i] <= 1; odd_cnt + 1.
  - Otherwise: k <= 2k. path[i] = 1 with an illegal branch silently falls back to doubling.
  - Doubling when k[W-1] = 1: k is held, ovf = 1, next state DONE, orbit not incremented.
  - orbit + 1 per completed step. After orbit reaches len, next state DONE (or CHECK when enabled).
- Division by 3 is a combinational constant divide on W bits; no multicycle path.
- DONE: lasts one cycle. done = 1, n_out = k. Next state IDLE.
- Latency: st edge at cycle 0; done high in cycle len+1. Error, ovf and len = 0 cases exit early.
- Outputs n_out, orbit, odd_cnt, taken, ovf, err hold until the next accepted st or rst.
- st while not IDLE is ignored, including st coincident with done. An st held high re-launches on the first IDLE cycle.
- rst mid-walk aborts immediately. No done pulse.

Optional Feature:
- Macro: COLLATZ_INV_CHECK_EN
- Defined:
  - CHECK state inserted between STEP and DONE, entered only when ovf = 0 and err = 0.
  - Runs the forward recurrence on a copy of k: k/2 if even, 3k+1 if odd, one step per cycle, for orbit cycles.
  - chk_ok = 1 if the final value equals the latched seed.
  - done latency becomes 2*len+1.
- Undefined: CHECK state absent; chk_ok tied 0.

Test Plan:
- seed=1, path=0, len=4 -> done in cycle 5; n_out=16, orbit=4, odd_cnt=0, taken=0, ovf=0.
- seed=16, path=0x0001, len=1 -> n_out=5, odd_cnt=1, taken=0x0001. Also seed=10, path=1, len=1 -> n_out=3.
- seed=4, path=0x0001, len=1 -> q=1 rejected; n_out=8, taken=0, odd_cnt=0.
- seed=1, path=0x0010, len=5 -> n_out=5, taken=0x0010, orbit=5. With COLLATZ_INV_CHECK_EN: chk_ok=1, done in cycle 11.
- seed=0x80000, path=0, len=3 -> ovf=1, n_out=0x80000, orbit=0, done in cycle 2. seed=0 -> err=1, done in cycle 1.
- Control cases:
  - st pulsed again during STEP -> ignored, first result unchanged.
  - rst in cycle 2 of a len=8 walk -> no done; all outputs 0 next cycle.
  - len=0 -> done in cycle 1 with n_out=seed.
